// File: rtl/pcecd_scsi_phase_seq.sv
// Drive-side SCSI phase sequencer for the PC Engine CD: BUS_FREE -> COMMAND -> EXEC -> STATUS -> MESSAGE_IN.
// Optional handshake watchdog enabled with `define PCECD_PHASE_TIMEOUT_EN (adds o_timeout).
module pcecd_scsi_phase_seq #(
    parameter int         TIMEOUT_CYCLES = 65535,
    parameter logic [7:0] MSG_BYTE       = 8'h00
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_sel,
    input  logic        i_ack,
    input  logic        i_bus_rst,
    input  logic [7:0]  i_db,
    input  logic        i_exec_done,
    input  logic [7:0]  i_exec_status,
    output logic [7:0]  o_status,
    output logic [7:0]  o_db,
    output logic [2:0]  o_phase,
    output logic        o_cmd_valid,
    output logic [3:0]  o_cmd_len,
    output logic [95:0] o_cmd_buf,
`ifdef PCECD_PHASE_TIMEOUT_EN
    output logic        o_irq_done,
    output logic        o_timeout
`else
    output logic        o_irq_done
`endif
);

    typedef enum logic [2:0] {
        PH_FREE = 3'd0,
        PH_CMD  = 3'd1,
        PH_EXEC = 3'd2,
        PH_STAT = 3'd3,
        PH_MSG  = 3'd4
    } phase_t;

    phase_t     phase;
    logic       bsy, req, msg, cd, io;
    logic [3:0] cnt;
    logic       ack_q, bus_rst_q;
    logic       ack_rise, bus_rst_rise;
    logic [3:0] tgt_len;
    logic       illegal;
    logic [7:0] opcode;

    assign ack_rise     = i_ack & ~ack_q;
    assign bus_rst_rise = i_bus_rst & ~bus_rst_q;
    assign o_status     = {bsy, req, msg, cd, io, 3'b000};
    assign o_phase      = phase;
    assign opcode       = o_cmd_buf[7:0];

    // Group code of byte 0 gives the CDB length; unknown groups are run as 6-byte and flagged.
    always_comb begin
        tgt_len = 4'd6;
        illegal = 1'b0;
        if (opcode <= 8'h1F)
            tgt_len = 4'd6;
        else if (opcode <= 8'h5F)
            tgt_len = 4'd10;
        else if (opcode >= 8'hA0 && opcode <= 8'hBF)
            tgt_len = 4'd12;
        else if (opcode >= 8'hD8 && opcode <= 8'hDF)
            tgt_len = 4'd10;
        else
            illegal = 1'b1;
    end

`ifdef PCECD_PHASE_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wd;
    logic        watched, stall;

    assign watched = (phase == PH_CMD) || (phase == PH_STAT) || (phase == PH_MSG);
    // Any REQ-changing event counts as handshake progress and restarts the watchdog.
    assign stall   = watched && !(ack_rise && req) && !(!req && !i_ack);
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            phase       <= PH_FREE;
            {bsy, req, msg, cd, io} <= 5'b0;
            o_db        <= 8'h00;
            o_cmd_buf   <= 96'h0;
            o_cmd_len   <= 4'd0;
            o_cmd_valid <= 1'b0;
            o_irq_done  <= 1'b0;
            cnt         <= 4'd0;
            ack_q       <= 1'b0;
            bus_rst_q   <= 1'b0;
`ifdef PCECD_PHASE_TIMEOUT_EN
            o_timeout   <= 1'b0;
            wd          <= 16'd0;
`endif
        end else begin
            ack_q       <= i_ack;
            bus_rst_q   <= i_bus_rst;
            o_cmd_valid <= 1'b0;
            o_irq_done  <= 1'b0;
`ifdef PCECD_PHASE_TIMEOUT_EN
            o_timeout   <= 1'b0;
`endif
            if (bus_rst_rise) begin
                // Same as a full reset, but the command buffer survives.
                phase     <= PH_FREE;
                {bsy, req, msg, cd, io} <= 5'b0;
                o_db      <= 8'h00;
                o_cmd_len <= 4'd0;
                cnt       <= 4'd0;
                ack_q     <= 1'b0;
            end else begin
                case (phase)
                    PH_FREE: begin
                        {bsy, req, msg, cd, io} <= 5'b0;
                        if (i_sel && !i_bus_rst) begin
                            phase <= PH_CMD;
                            {bsy, req, msg, cd, io} <= 5'b11010;
                            cnt   <= 4'd0;
                        end
                    end
                    PH_CMD: begin
                        if (ack_rise && req) begin
                            for (int n = 0; n < 12; n++)
                                if (cnt == 4'(n))
                                    o_cmd_buf[8*n +: 8] <= i_db;
                            cnt <= cnt + 4'd1;
                            req <= 1'b0;
                        end else if (!req && !i_ack) begin
                            if (cnt == tgt_len) begin
                                o_cmd_valid <= 1'b1;
                                o_cmd_len   <= tgt_len;
                                phase       <= PH_EXEC;
                                cd          <= 1'b0;
                            end else if (cnt < tgt_len) begin
                                req <= 1'b1;
                            end
                        end
                    end
                    PH_EXEC: begin
                        bsy <= 1'b1;
                        req <= 1'b0;
                        // Illegal opcodes are answered locally with CHECK CONDITION.
                        if (illegal || i_exec_done) begin
                            o_db  <= illegal ? 8'h02 : i_exec_status;
                            cd    <= 1'b1;
                            io    <= 1'b1;
                            req   <= 1'b1;
                            phase <= PH_STAT;
                        end
                    end
                    PH_STAT: begin
                        if (ack_rise && req) begin
                            req <= 1'b0;
                        end else if (!req && !i_ack) begin
                            o_db  <= MSG_BYTE;
                            msg   <= 1'b1;
                            req   <= 1'b1;
                            phase <= PH_MSG;
                        end
                    end
                    PH_MSG: begin
                        if (ack_rise && req) begin
                            req <= 1'b0;
                        end else if (!req && !i_ack) begin
                            {bsy, req, msg, cd, io} <= 5'b0;
                            o_db       <= 8'h00;
                            o_irq_done <= 1'b1;
                            phase      <= PH_FREE;
                        end
                    end
                    default: begin
                        phase <= PH_FREE;
                        {bsy, req, msg, cd, io} <= 5'b0;
                    end
                endcase
`ifdef PCECD_PHASE_TIMEOUT_EN
                if (!stall) begin
                    wd <= 16'd0;
                end else if (wd == WD_LAST) begin
                    {bsy, req, msg, cd, io} <= 5'b0;
                    o_db      <= 8'h00;
                    phase     <= PH_FREE;
                    o_timeout <= 1'b1;
                    wd        <= 16'd0;
                end else begin
                    wd <= wd + 16'd1;
                end
`endif
            end
        end
    end

endmodule

// File: doc/pcecd_scsi_phase_seq.md
Name: pcecd_scsi_phase_seq

Overview:
Drive-side SCSI phase sequencer for the PC Engine CD interface. It owns the BSY/REQ/MSG/CD/IO target signals and the DB output. It steps the bus through BUS_FREE -> COMMAND -> EXEC -> STATUS -> MESSAGE_IN -> BUS_FREE using a REQ/ACK byte handshake. Incoming command bytes are collected into a buffer and handed to the command executor. The block sits between the $1800-$1804 register front end (initiator SEL/ACK/RST/DB) and the command executor.

Parameters:
TIMEOUT_CYCLES, 65535, handshake watchdog limit in clocks; used only with the optional feature.
MSG_BYTE, 8'h00, message byte sent in MESSAGE_IN (COMMAND COMPLETE).

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous active-high reset
i_sel  in  1  initiator SEL (written via $1800)
i_ack  in  1  initiator ACK ($1802 bit 7)
i_bus_rst  in  1  initiator RST ($1804 bit 1)
i_db  in  8  initiator data bus (command bytes)
i_exec_done  in  1  one-cycle pulse: executor finished command
i_exec_status  in  8  status byte, sampled with i_exec_done
o_status  out  8  {BSY,REQ,MSG,CD,IO,3'b000}, i.e. $1800 read value
o_db  out  8  target data bus
o_phase  out  3  0 BUS_FREE, 1 COMMAND, 2 EXEC, 3 STATUS, 4 MESSAGE_IN
o_cmd_valid  out  1  one-cycle pulse: command buffer complete
o_cmd_len  out  4  byte count of captured command (6/10/12)
o_cmd_buf  out  96  bytes 0..11; byte n at [8n+7:8n]
o_irq_done  out  1  one-cycle pulse on return to BUS_FREE after MESSAGE_IN

Behaviour:
- Reset (i_rst = 1): phase BUS_FREE; o_status = 0; o_db = 0; o_cmd_buf = 0; o_cmd_len = 0; all pulses 0; byte counter 0; ack_q = 0.
- Reset has priority over every other event and can occur in any state.
- Bus reset: a rising edge of i_bus_rst (registered previous value 0, current 1) has the same effect as i_rst except o_cmd_buf is kept. While i_bus_rst stays high, the block holds BUS_FREE and ignores i_sel.
- ACK edge: ack_rise = i_ack & ~ack_q, where ack_q is i_ack registered.
- BUS_FREE:
  - All target bits are 0.
  - On i_sel = 1 -> COMMAND with BSY = 1, CD = 1, IO = 0, MSG = 0, REQ = 1, counter = 0. This takes 1 cycle (visible the cycle after SEL).
- COMMAND:
  - On ack_rise with REQ = 1: latch i_db into byte[counter], increment the counter, and set REQ = 0 on the same edge.
  - If REQ = 0 and i_ack = 0, and counter < target length: set REQ = 1 on the next edge.
  - Target length is decoded from byte 0 once it is captured:
    - 0x00-0x1F -> 6
    - 0x20-0x5F -> 10
    - 0xA0-0xBF -> 12
    - 0xD8-0xDF -> 10 (NEC vendor)
    - all other values -> 6, with the illegal flag set.
  - When counter = length, REQ = 0 and i_ack = 0: pulse o_cmd_valid, drive o_cmd_len, and move to EXEC.
  - ACK that is held high does not re-trigger; a new rising edge is required per byte.
- EXEC:
  - BSY = 1, REQ = 0. Wait for i_exec_done.
  - If the illegal flag is set, skip the wait: use status 8'h02 (CHECK CONDITION) one cycle after entry. o_cmd_valid is still pulsed; the executor ignores it.
  - On exit: o_db = status, CD = 1, IO = 1, REQ = 1, -> STATUS.
- STATUS:
  - On ack_rise: REQ = 0.
  - Then on i_ack = 0: o_db = MSG_BYTE, MSG = 1, REQ = 1, -> MESSAGE_IN.
- MESSAGE_IN:
  - On ack_rise: REQ = 0.
  - Then on i_ack = 0: clear all target bits, pulse o_irq_done, -> BUS_FREE.
- Stray events:
  - i_sel outside BUS_FREE is ignored.
  - i_exec_done outside EXEC is ignored.
  - ack_rise while REQ = 0 is ignored.
- Simultaneous events: i_sel and ack_rise in BUS_FREE gives SEL only. A bus-reset edge together with any handshake gives reset.
- o_cmd_buf bytes beyond o_cmd_len hold stale values. They are cleared on reset only.

Optional Feature:
PCECD_PHASE_TIMEOUT_EN
- Defined: a 16-bit watchdog counts clocks while in COMMAND, STATUS or MESSAGE_IN with no ack_rise and no ACK-low completion.
  - The counter resets on every phase change and every handshake edge.
  - On reaching TIMEOUT_CYCLES: all target bits are cleared, the block goes to BUS_FREE, and an extra output o_timeout (1 bit) pulses for one cycle. o_irq_done does not pulse.
  - EXEC is not watched.
- Undefined: no counter and no o_timeout port. The block waits indefinitely.

Test Plan:
- TEST UNIT READY: SEL pulse, then 6 ACK handshakes with bytes 00 00 00 00 00 00, i_exec_done with status 00 -> o_status goes 0xD0 (BSY/CD/REQ), then o_cmd_valid pulse with o_cmd_len = 6, then STATUS o_status = 0xD8 with o_db = 00, then MESSAGE_IN o_status = 0xF8 with o_db = 00, then o_irq_done pulse and o_status = 0.
- NEC 10-byte command: bytes D8 00 00 00 00 00 00 00 00 00 -> o_cmd_len = 10, o_cmd_buf[7:0] = D8, exactly 10 REQ assertions.
- Illegal opcode 0x60 followed by 5 more bytes -> no i_exec_done needed; STATUS o_db = 02 one cycle after EXEC entry.
- ACK held high for 20 cycles after the first byte -> only one byte captured; counter = 1; REQ stays 0 until ACK falls.
- i_bus_rst rising mid-COMMAND after 3 bytes -> next cycle o_phase = 0 and o_status = 0; a following SEL restarts with counter = 0.
- i_rst asserted in STATUS -> all outputs at reset values the next cycle; with PCECD_PHASE_TIMEOUT_EN and TIMEOUT_CYCLES = 16, stall in COMMAND -> o_timeout pulses at cycle 16 and o_phase = 0.
